output_demux: RTL and testbench
===============================

OUTPUT_DEMUX -- requirements
Module: output_demux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data word width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, ctrl word width.
REQ-003 SHALL have parameter NUM_PORTS, default 4, number of output ports (2..8).
REQ-004 SHALL have parameter HDR_CTRL, default 8'hFF, ctrl value marking the IOQ module header word.
REQ-005 SHALL have parameter DST_LSB, default 16, LSB of the one-hot destination mask inside the header data word (mask = data[DST_LSB+NUM_PORTS-1:DST_LSB]).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_data, input, DATA_WIDTH, upstream data word.
REQ-009 SHALL have port in_ctrl, input, CTRL_WIDTH, upstream ctrl word.
REQ-010 SHALL have port in_wr, input, 1, upstream write strobe.
REQ-011 SHALL have port in_rdy, output, 1, block can accept words.
REQ-012 SHALL have port out_data, output, DATA_WIDTH, shared data bus to all ports.
REQ-013 SHALL have port out_ctrl, output, CTRL_WIDTH, shared ctrl bus to all ports.
REQ-014 SHALL have port out_wr, output, NUM_PORTS, per-port write strobe.
REQ-015 SHALL have port out_rdy, input, NUM_PORTS, per-port ready.
REQ-016 SHALL have port drop_cnt, output, 16, dropped-packet count.

Function
REQ-017 SHALL buffer input in a 4-entry first-word-fall-through FIFO; in_rdy = !nearly_full (≤1 free entry → in_rdy low); in_wr while full SHALL be ignored (word lost).
REQ-018 SHALL run FSM states IDLE, WR_PKT, DROP.
REQ-019 IDLE: when FIFO non-empty, inspect head word without reading; if head ctrl==HDR_CTRL and effective mask≠0, latch mask, go WR_PKT; otherwise go DROP and increment drop_cnt.
REQ-020 WR_PKT: when FIFO non-empty and every masked port has out_rdy=1, read one word and register it to out_data/out_ctrl with out_wr=mask the next cycle; otherwise stall, out_wr=0.
REQ-021 DROP: read one word per cycle while FIFO non-empty; out_wr stays 0.
REQ-022 End of packet SHALL be a word with ctrl≠0 whose preceding word in the same packet had ctrl==0; prev-ctrl tracker SHALL be set nonzero at packet start so the header is never EOP.
REQ-023 On reading the EOP word, SHALL return to IDLE; the next packet's header is examined no earlier than the following cycle.
REQ-024 Latency: header written at edge N → out_wr asserted in cycle after edge N+2 when all masked ports ready.
REQ-025 drop_cnt SHALL wrap 16'hFFFF→0.
REQ-026 Unmasked ports SHALL never see out_wr=1; out_data/out_ctrl may change freely when out_wr=0.

Reset
REQ-027 reset low SHALL asynchronously force state IDLE, FIFO empty, out_wr=0, out_data=0, out_ctrl=0, drop_cnt=0, latched mask=0.
REQ-028 Reset mid-packet SHALL discard the partial packet; no recovery of truncated downstream packet.

Configuration
REQ-029 With OUTPUT_DEMUX_MCAST_EN defined, effective mask = full header mask (multicast, word written to all masked ports simultaneously).
REQ-030 Without OUTPUT_DEMUX_MCAST_EN, effective mask = lowest set bit of header mask only (unicast).

Verification
REQ-031 Header mask 4'b0010, 3 data words ctrl 0, EOP ctrl 8'h80, all ready -> 5 words on port 1 only, out_wr=4'b0010, header at latency per REQ-024.
REQ-032 Header mask 4'b0000 -> whole packet consumed, out_wr never set, drop_cnt 0→1.
REQ-033 Mask 4'b0101 with MCAST_EN, out_rdy[2] low for 10 cycles -> no writes during stall, then words on ports 0 and 2 together; without MCAST_EN -> port 0 only.
REQ-034 Back-to-back packets to ports 0 then 3, in_wr continuous -> in_rdy deasserts when FIFO reaches 3 entries, both packets delivered intact, no lost words.
REQ-035 First word ctrl 8'h00 (no header) -> packet dropped up to EOP, drop_cnt increments.
REQ-036 reset asserted mid-WR_PKT -> all outputs 0 immediately, next header after release forwarded correctly.

Source files
------------

// File: rtl/output_demux.sv
// Output demux: buffers IOQ packets in a 4-deep FWFT FIFO and forwards each to the ports
// selected by its header mask. Define OUTPUT_DEMUX_MCAST_EN for multicast, else unicast.
module output_demux #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned           NUM_PORTS  = 4,
    parameter logic [CTRL_WIDTH-1:0] HDR_CTRL   = 8'hFF,
    parameter int unsigned           DST_LSB    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [NUM_PORTS-1:0]  out_wr,
    input  logic [NUM_PORTS-1:0]  out_rdy,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned FIFO_DEPTH = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WR_PKT = 2'd1;
    localparam logic [1:0] ST_DROP   = 2'd2;

    localparam logic [NUM_PORTS-1:0] MASK_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [CTRL_WIDTH-1:0] fifo_ctrl [FIFO_DEPTH];
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    logic [2:0]            count_q;
    logic [2:0]            count_d;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_nearly_full;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign fifo_empty       = (count_q == 3'd0);
    assign fifo_full        = (count_q == 3'd4);
    assign fifo_nearly_full = (count_q >= 3'd3);
    assign in_rdy           = !fifo_nearly_full;
    // Writes while full are dropped on the floor; upstream should honour in_rdy.
    assign fifo_wr          = in_wr && !fifo_full;
    assign head_data        = fifo_data[rd_ptr_q];
    assign head_ctrl        = fifo_ctrl[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_data[wr_ptr_q] <= in_data;
            fifo_ctrl[wr_ptr_q] <= in_ctrl;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

    logic [NUM_PORTS-1:0] hdr_mask;
    logic [NUM_PORTS-1:0] eff_mask;

    assign hdr_mask = head_data[DST_LSB +: NUM_PORTS];
`ifdef OUTPUT_DEMUX_MCAST_EN
    assign eff_mask = hdr_mask;
`else
    // Isolate the lowest set bit.
    assign eff_mask = hdr_mask & (~hdr_mask + MASK_ONE);
`endif

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [NUM_PORTS-1:0]  mask_q;
    logic [NUM_PORTS-1:0]  mask_d;
    logic                  prev_zero_q;
    logic                  prev_zero_d;
    logic [15:0]           drop_cnt_d;
    logic [DATA_WIDTH-1:0] out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_d;
    logic [NUM_PORTS-1:0]  out_wr_d;
    logic                  ports_ready;
    logic                  head_eop;

    assign ports_ready = ((out_rdy & mask_q) == mask_q);
    // EOP is the first nonzero ctrl after a zero ctrl; prev_zero is cleared at packet start.
    assign head_eop    = (head_ctrl != '0) && prev_zero_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        prev_zero_d = prev_zero_q;
        drop_cnt_d  = drop_cnt;
        out_data_d  = out_data;
        out_ctrl_d  = out_ctrl;
        out_wr_d    = '0;
        fifo_rd     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    prev_zero_d = 1'b0;
                    if ((head_ctrl == HDR_CTRL) && (eff_mask != '0)) begin
                        mask_d  = eff_mask;
                        state_d = ST_WR_PKT;
                    end else begin
                        drop_cnt_d = drop_cnt + 16'd1;
                        state_d    = ST_DROP;
                    end
                end
            end
            ST_WR_PKT: begin
                if (!fifo_empty && ports_ready) begin
                    fifo_rd     = 1'b1;
                    out_data_d  = head_data;
                    out_ctrl_d  = head_ctrl;
                    out_wr_d    = mask_q;
                    prev_zero_d = (head_ctrl == '0);
                    if (head_eop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (!fifo_empty) begin
                    fifo_rd     = 1'b1;
                    prev_zero_d = (head_ctrl == '0);
                    if (head_eop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            prev_zero_q <= 1'b0;
            drop_cnt    <= '0;
            out_data    <= '0;
            out_ctrl    <= '0;
            out_wr      <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            prev_zero_q <= prev_zero_d;
            drop_cnt    <= drop_cnt_d;
            out_data    <= out_data_d;
            out_ctrl    <= out_ctrl_d;
            out_wr      <= out_wr_d;
        end
    end

endmodule

// File: tb/tb_output_demux.sv
// Scoreboard bench for output_demux: stimulus pushes expected writes, a monitor pops and compares.
module tb_output_demux;

`ifdef OUTPUT_DEMUX_MCAST_EN
    localparam bit MCAST = 1'b1;
`else
    localparam bit MCAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [3:0]  out_wr;
    logic [3:0]  out_rdy;
    logic [15:0] drop_cnt;

    output_demux dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .drop_cnt (drop_cnt)
    );

    typedef struct {
        logic [3:0]  wr;
        logic [7:0]  ctrl;
        logic [63:0] data;
        int          exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks       = 0;
    int   failures     = 0;
    int   cyc          = 0;
    int   last_put_cyc = 0;
    int   exp_drops    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [3:0] m);
        logic [63:0] h;
        h        = 64'hA5A5_0000_C3C3_0000;
        h[19:16] = m;
        return h;
    endfunction

    task automatic put_word(input logic [63:0] d, input logic [7:0] c);
        int waited = 0;
        while (!in_rdy && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_rdy) begin
            checks++;
            failures++;
            $display("FAIL put_timeout: in_rdy got 0 expected 1");
        end else begin
            in_data      = d;
            in_ctrl      = c;
            in_wr        = 1'b1;
            last_put_cyc = cyc;
            @(posedge clk);
            #1;
            in_wr = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [3:0] w, input logic [7:0] c, input logic [63:0] d,
                            input int ec);
        exp_t e;
        e.wr      = w;
        e.ctrl    = c;
        e.data    = d;
        e.exp_cyc = ec;
        sb.push_back(e);
    endtask

    task automatic fwd_word(input logic [3:0] w, input logic [63:0] d, input logic [7:0] c);
        put_word(d, c);
        push_exp(w, c, d, -1);
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle with a write must match the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_wr != 4'b0000) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: out_wr got %b expected 0000", out_wr);
                end else begin
                    e = sb.pop_front();
                    check("out_wr", {60'd0, out_wr}, {60'd0, e.wr});
                    check("out_ctrl", {56'd0, out_ctrl}, {56'd0, e.ctrl});
                    check("out_data", out_data, e.data);
                    if (e.exp_cyc >= 0) begin
                        check("hdr_latency", cyc, e.exp_cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stall_writes;
        logic [3:0] m33;
        reset   = 1'b0;
        in_wr   = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        out_rdy = 4'b1111;
        idle_wait(2);
        check("rst_out_wr", {60'd0, out_wr}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        check("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        check("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        idle_wait(1);

        // Unicast to port 1 with header latency check.
        put_word(hdr(4'b0010), 8'hFF);
        push_exp(4'b0010, 8'hFF, hdr(4'b0010), last_put_cyc + 3);
        fwd_word(4'b0010, 64'h1111_0000_0000_0001, 8'h00);
        fwd_word(4'b0010, 64'h1111_0000_0000_0002, 8'h00);
        fwd_word(4'b0010, 64'h1111_0000_0000_0003, 8'h00);
        fwd_word(4'b0010, 64'h1111_0000_0000_0004, 8'h80);
        idle_wait(10);
        check("p1_drained", sb.size(), 64'd0);

        // Empty mask: dropped.
        put_word(hdr(4'b0000), 8'hFF);
        put_word(64'h2222_0000_0000_0001, 8'h00);
        put_word(64'h2222_0000_0000_0002, 8'h00);
        put_word(64'h2222_0000_0000_0003, 8'h80);
        idle_wait(10);
        exp_drops = 1;
        check("drop_mask0", {48'd0, drop_cnt}, exp_drops);
        check("drop_mask0_in_rdy", {63'd0, in_rdy}, 64'd1);

        // No header: dropped through EOP.
        put_word(64'h3333_0000_0000_0001, 8'h00);
        put_word(64'h3333_0000_0000_0002, 8'h00);
        put_word(64'h3333_0000_0000_0003, 8'h40);
        idle_wait(10);
        exp_drops = 2;
        check("drop_nohdr", {48'd0, drop_cnt}, exp_drops);

        // Mask 0101 with port 2 stalled.
        m33     = MCAST ? 4'b0101 : 4'b0001;
        out_rdy = 4'b1011;
        fwd_word(m33, hdr(4'b0101), 8'hFF);
        fwd_word(m33, 64'h4444_0000_0000_0001, 8'h00);
        stall_writes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_wr != 4'b0000) stall_writes++;
        end
`ifdef OUTPUT_DEMUX_MCAST_EN
        check("mcast_stall_writes", stall_writes, 64'd0);
        check("mcast_stall_pending", sb.size(), 64'd2);
`endif
        out_rdy = 4'b1111;
        #1;
        fwd_word(m33, 64'h4444_0000_0000_0002, 8'h00);
        fwd_word(m33, 64'h4444_0000_0000_0003, 8'h80);
        idle_wait(10);
        check("p3_drained", sb.size(), 64'd0);

        // Back-to-back packets to ports 0 then 3, FIFO filled while blocked.
        out_rdy = 4'b0000;
        fwd_word(4'b0001, hdr(4'b0001), 8'hFF);
        fwd_word(4'b0001, 64'h5555_0000_0000_0001, 8'h00);
        check("fill2_in_rdy", {63'd0, in_rdy}, 64'd1);
        fwd_word(4'b0001, 64'h5555_0000_0000_0002, 8'h00);
        check("fill3_in_rdy", {63'd0, in_rdy}, 64'd0);
        out_rdy = 4'b1111;
        fwd_word(4'b0001, 64'h5555_0000_0000_0003, 8'h80);
        fwd_word(4'b1000, hdr(4'b1000), 8'hFF);
        fwd_word(4'b1000, 64'h6666_0000_0000_0001, 8'h00);
        fwd_word(4'b1000, 64'h6666_0000_0000_0002, 8'h40);
        idle_wait(12);
        check("b2b_drained", sb.size(), 64'd0);
        check("b2b_drops", {48'd0, drop_cnt}, exp_drops);

        // Reset in the middle of a forwarded packet.
        put_word(hdr(4'b0100), 8'hFF);
        push_exp(4'b0100, 8'hFF, hdr(4'b0100), last_put_cyc + 3);
        fwd_word(4'b0100, 64'h7777_0000_0000_0001, 8'h00);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_drained", sb.size(), 64'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_out_wr", {60'd0, out_wr}, 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
        check("mid_rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
        exp_drops = 0;
        @(negedge clk);
        reset = 1'b1;
        idle_wait(1);
        put_word(hdr(4'b0100), 8'hFF);
        push_exp(4'b0100, 8'hFF, hdr(4'b0100), last_put_cyc + 3);
        fwd_word(4'b0100, 64'h8888_0000_0000_0001, 8'h00);
        fwd_word(4'b0100, 64'h8888_0000_0000_0002, 8'h80);

        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clk);
        end
        idle_wait(8);
        check("final_drained", sb.size(), 64'd0);
        check("final_drop_cnt", {48'd0, drop_cnt}, exp_drops);
        check("final_in_rdy", {63'd0, in_rdy}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
